arch_map_retire: RTL and testbench
==================================

ARCH_MAP_RETIRE -- requirements
Module: arch_map_retire

Interface
REQ-001 The block SHALL take parameters, one per line: name, default, meaning:
  COMMIT_WIDTH  4  retire lanes per cycle
  NUM_ARCH_REGS  64  architectural registers, power of two
  SIZE_PHYSICAL_LOG  7  physical register tag width
  COPY_PER_CYCLE  4  AMT entries copied per recovery cycle; divides NUM_ARCH_REGS
REQ-002 The block SHALL have these ports, one per line: name  direction  width  meaning:
  clk  in  1  single clock, rising edge
  reset  in  1  asynchronous, active-low reset
  commitValid_i  in  COMMIT_WIDTH  lane i retires an instruction with a destination
  commitArch_i  in  COMMIT_WIDTH x log2(NUM_ARCH_REGS)  architectural destination per lane
  commitPhy_i  in  COMMIT_WIDTH x SIZE_PHYSICAL_LOG  new physical register per lane
  recoverFlag_i  in  1  start the AMT-to-RMT copy
  freedPhyReg_o  out  COMMIT_WIDTH x phys_reg  {valid, reg_id} freed registers, to the free list
  rmtWrEn_o  out  1  RMT write strobe
  rmtWrAddr_o  out  log2(NUM_ARCH_REGS)  first arch index of this copy beat
  rmtWrData_o  out  COPY_PER_CYCLE x SIZE_PHYSICAL_LOG  AMT entries rmtWrAddr_o .. rmtWrAddr_o+COPY_PER_CYCLE-1
  recoverBusy_o  out  1  copy in progress
  recoverDone_o  out  1  one-cycle pulse after the final copy beat

Function
REQ-003 The AMT SHALL be NUM_ARCH_REGS x SIZE_PHYSICAL_LOG flops, one entry per architectural register.
REQ-004 For each valid lane i, the old mapping SHALL be AMT[commitArch_i[i]], unless a lower lane j<i is valid with the same arch; in that case it is commitPhy_i of the highest such j.
REQ-005 freedPhyReg_o[i] SHALL be registered: valid=commitValid_i[i] and reg_id=old mapping of lane i, one cycle after the commit.
REQ-006 Lane order SHALL be preserved; invalid lanes output valid=0 and reg_id=0; there is no compaction, because the free list compacts.
REQ-007 On each clock edge, AMT[a] SHALL take commitPhy_i of the highest valid lane whose arch is a; other entries hold.
REQ-008 The free list always accepts freed registers; there is no backpressure and no stall input.
REQ-009 The copy FSM SHALL have two states, IDLE and COPY, with a beat counter of log2(NUM_ARCH_REGS/COPY_PER_CYCLE) bits.
REQ-010 IDLE with recoverFlag_i=1 -> COPY with counter=0; recoverBusy_o=1 from the next cycle.
REQ-011 In COPY, each cycle SHALL assert rmtWrEn_o, drive rmtWrAddr_o=counter*COPY_PER_CYCLE and rmtWrData_o from the current AMT (combinational read, post-reset state, pre-update for same-cycle commits), then increment the counter.
REQ-012 On the final beat (counter=max), the FSM SHALL return to IDLE and assert recoverDone_o for exactly the following cycle, with recoverBusy_o=0 in that cycle.
REQ-013 recoverFlag_i asserted while in COPY SHALL restart the copy: counter=0 on the next cycle, no recoverDone_o for the aborted pass.
REQ-014 Commits during COPY SHALL still update the AMT and free registers; beats already sent are not re-sent.
REQ-015 recoverFlag_i in the cycle of the final beat SHALL restart the copy and suppress recoverDone_o.
REQ-016 A full copy SHALL take NUM_ARCH_REGS/COPY_PER_CYCLE cycles (16 at defaults).

Reset
REQ-017 While reset=0, AMT[a] SHALL equal a for all a, so the free list holds tags NUM_ARCH_REGS and above.
REQ-018 While reset=0, all freedPhyReg_o valid and reg_id, rmtWrEn_o, rmtWrAddr_o, rmtWrData_o, recoverBusy_o and recoverDone_o SHALL be 0, and the FSM SHALL be IDLE with counter 0.
REQ-019 Reset asserted mid-COPY SHALL abort the copy immediately (asynchronous) with no recoverDone_o.
REQ-020 Output and AMT resets SHALL take effect asynchronously on the falling edge of reset; deassertion is clock-synchronous-safe.

Verification
REQ-021 Single-lane retire: after reset, commit lane0 arch 5 -> phy 70 -> next cycle freedPhyReg_o[0]={1,5}; AMT[5]=70.
REQ-022 Intra-group same-arch: lanes 0, 1, 3 valid, arch 7, phy 80/81/82, after reset -> freed {1,7},{1,80},{0,0},{1,81}; AMT[7]=82.
REQ-023 Sparse lanes: only lanes 1 and 3 valid (arch 2 phy 90, arch 9 phy 91) -> freed[1]={1,2}, freed[3]={1,9}, lanes 0 and 2 invalid.
REQ-024 Full copy: recoverFlag_i pulse after REQ-021 -> 16 beats with addr 0,4,...,60; beat 1 data[1]=70; recoverDone_o on cycle 17 after the pulse.
REQ-025 Restart and reset: recoverFlag_i re-pulsed at beat 9 -> addr returns to 0 and done arrives 16 beats later; separate run: reset=0 at beat 5 -> busy=0, no done, AMT identity.

Source files
------------

// File: rtl/arch_map_retire.sv
// Architectural map table: retires committed mappings, frees the displaced physical tags,
// and on recovery streams the AMT into the RMT COPY_PER_CYCLE entries per beat.
// state | meaning:  S_IDLE | no copy running;  S_COPY | one RMT write beat per cycle
module arch_map_retire #(
  parameter int COMMIT_WIDTH      = 4,
  parameter int NUM_ARCH_REGS     = 64,
  parameter int SIZE_PHYSICAL_LOG = 7,
  parameter int COPY_PER_CYCLE    = 4,
  localparam int AW    = $clog2(NUM_ARCH_REGS),
  localparam int PW    = SIZE_PHYSICAL_LOG,
  localparam int BEATS = NUM_ARCH_REGS / COPY_PER_CYCLE,
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [COMMIT_WIDTH-1:0]                  commitValid_i,
  input  logic [COMMIT_WIDTH-1:0][AW-1:0]          commitArch_i,
  input  logic [COMMIT_WIDTH-1:0][PW-1:0]          commitPhy_i,
  input  logic                                     recoverFlag_i,
  output logic [COMMIT_WIDTH-1:0][PW:0]            freedPhyReg_o,
  output logic                                     rmtWrEn_o,
  output logic [AW-1:0]                            rmtWrAddr_o,
  output logic [COPY_PER_CYCLE-1:0][PW-1:0]        rmtWrData_o,
  output logic                                     recoverBusy_o,
  output logic                                     recoverDone_o
);

  localparam logic [CW-1:0] CNT_MAX = CW'(BEATS - 1);

  typedef enum logic {S_IDLE, S_COPY} state_e;

  logic [NUM_ARCH_REGS-1:0][PW-1:0] amt_q, amt_d;
  logic [COMMIT_WIDTH-1:0][PW:0]    freed_q, freed_d;
  logic [COMMIT_WIDTH-1:0][PW-1:0]  old_map;
  state_e                           state_q, state_d;
  logic [CW-1:0]                    cnt_q, cnt_d;
  logic                             done_q, done_d;
  logic [AW-1:0]                    beat_base;

  // Old mapping forwards from the highest lower lane retiring the same arch register.
  always_comb begin
    old_map = '0;
    freed_d = '0;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      old_map[i] = amt_q[commitArch_i[i]];
      for (int j = 0; j < COMMIT_WIDTH; j++) begin
        if (j < i && commitValid_i[j] && commitArch_i[j] == commitArch_i[i]) begin
          old_map[i] = commitPhy_i[j];
        end
      end
      if (commitValid_i[i]) begin
        freed_d[i] = {1'b1, old_map[i]};
      end
    end
  end

  always_comb begin
    amt_d = amt_q;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      if (commitValid_i[i]) begin
        amt_d[commitArch_i[i]] = commitPhy_i[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int a = 0; a < NUM_ARCH_REGS; a++) begin
        amt_q[a] <= PW'(a);
      end
      freed_q <= '0;
    end else begin
      amt_q   <= amt_d;
      freed_q <= freed_d;
    end
  end

  assign beat_base = AW'(int'(cnt_q) * COPY_PER_CYCLE);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    done_d      = 1'b0;
    rmtWrEn_o   = 1'b0;
    rmtWrAddr_o = '0;
    rmtWrData_o = '0;
    case (state_q)
      S_IDLE: begin
        if (recoverFlag_i) begin
          state_d = S_COPY;
          cnt_d   = '0;
        end
      end
      S_COPY: begin
        rmtWrEn_o   = 1'b1;
        rmtWrAddr_o = beat_base;
        for (int k = 0; k < COPY_PER_CYCLE; k++) begin
          rmtWrData_o[k] = amt_q[beat_base + AW'(k)];
        end
        // A new recovery request wins over completion, so an aborted pass never signals done.
        if (recoverFlag_i) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign freedPhyReg_o = freed_q;
  assign recoverBusy_o = (state_q == S_COPY);
  assign recoverDone_o = done_q;

endmodule

// File: tb/tb_arch_map_retire.sv
// Bench for arch_map_retire: directed scenarios plus random retire/recover traffic,
// all checked against an in-order array model of the AMT and a beat-count copy model.
module tb_arch_map_retire;

  localparam int NCW   = 4;
  localparam int NA    = 64;
  localparam int PW    = 7;
  localparam int CPC   = 4;
  localparam int AW    = 6;
  localparam int BEATS = NA / CPC;

  logic                      clk = 1'b0;
  logic                      reset;
  logic [NCW-1:0]            commitValid_i;
  logic [NCW-1:0][AW-1:0]    commitArch_i;
  logic [NCW-1:0][PW-1:0]    commitPhy_i;
  logic                      recoverFlag_i;
  logic [NCW-1:0][PW:0]      freedPhyReg_o;
  logic                      rmtWrEn_o;
  logic [AW-1:0]             rmtWrAddr_o;
  logic [CPC-1:0][PW-1:0]    rmtWrData_o;
  logic                      recoverBusy_o;
  logic                      recoverDone_o;

  arch_map_retire #(
    .COMMIT_WIDTH(NCW), .NUM_ARCH_REGS(NA), .SIZE_PHYSICAL_LOG(PW), .COPY_PER_CYCLE(CPC)
  ) dut (
    .clk(clk), .reset(reset),
    .commitValid_i(commitValid_i), .commitArch_i(commitArch_i), .commitPhy_i(commitPhy_i),
    .recoverFlag_i(recoverFlag_i), .freedPhyReg_o(freedPhyReg_o),
    .rmtWrEn_o(rmtWrEn_o), .rmtWrAddr_o(rmtWrAddr_o), .rmtWrData_o(rmtWrData_o),
    .recoverBusy_o(recoverBusy_o), .recoverDone_o(recoverDone_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  int         m_amt[NA];
  logic [7:0] m_freed[NCW];
  bit         m_active;
  int         m_beat;
  bit         m_done;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    commitValid_i = '0;
    commitArch_i  = '0;
    commitPhy_i   = '0;
    recoverFlag_i = 1'b0;
  endtask

  task automatic model_reset();
    for (int a = 0; a < NA; a++) m_amt[a] = a;
    for (int i = 0; i < NCW; i++) m_freed[i] = '0;
    m_active = 1'b0;
    m_beat   = 0;
    m_done   = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    for (int i = 0; i < NCW; i++) chk_eq({tag, "_freed"}, freedPhyReg_o[i], 0);
    chk_eq({tag, "_wren"}, rmtWrEn_o, 0);
    chk_eq({tag, "_addr"}, rmtWrAddr_o, 0);
    chk_eq({tag, "_data"}, rmtWrData_o, 0);
    chk_eq({tag, "_busy"}, recoverBusy_o, 0);
    chk_eq({tag, "_done"}, recoverDone_o, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    reset = 1'b0;
    idle_inputs();
    #2;
    chk_reset_outputs("rst");
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic check_outputs();
    for (int i = 0; i < NCW; i++) chk_eq("m_freed", freedPhyReg_o[i], m_freed[i]);
    chk_eq("m_busy", recoverBusy_o, m_active);
    chk_eq("m_done", recoverDone_o, m_done);
    chk_eq("m_wren", rmtWrEn_o, m_active);
    if (m_active) begin
      chk_eq("m_addr", rmtWrAddr_o, m_beat * CPC);
      for (int k = 0; k < CPC; k++) chk_eq("m_data", rmtWrData_o[k], m_amt[m_beat * CPC + k]);
    end
  endtask

  // Lanes retire in program order: each lane displaces whatever the map holds at that point.
  task automatic model_update();
    logic [7:0] nf[NCW];
    for (int i = 0; i < NCW; i++) nf[i] = '0;
    for (int i = 0; i < NCW; i++) begin
      if (commitValid_i[i]) begin
        nf[i] = {1'b1, PW'(m_amt[commitArch_i[i]])};
        m_amt[commitArch_i[i]] = commitPhy_i[i];
      end
    end
    for (int i = 0; i < NCW; i++) m_freed[i] = nf[i];
    if (recoverFlag_i) begin
      m_active = 1'b1;
      m_beat   = 0;
      m_done   = 1'b0;
    end else if (m_active && m_beat == BEATS - 1) begin
      m_active = 1'b0;
      m_done   = 1'b1;
    end else begin
      if (m_active) m_beat++;
      m_done = 1'b0;
    end
  endtask

  task automatic cycle();
    check_outputs();
    model_update();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    do_reset();

    // single-lane retire
    commitValid_i = 4'b0001; commitArch_i[0] = 6'd5; commitPhy_i[0] = 7'd70;
    cycle();
    idle_inputs();
    chk_eq("single_freed0", freedPhyReg_o[0], 8'h85);
    for (int i = 1; i < NCW; i++) chk_eq("single_freed_hi", freedPhyReg_o[i], 0);

    // full copy
    recoverFlag_i = 1'b1;
    cycle();
    recoverFlag_i = 1'b0;
    for (int n = 1; n <= BEATS; n++) begin
      chk_eq("copy_busy", recoverBusy_o, 1);
      chk_eq("copy_nodone", recoverDone_o, 0);
      chk_eq("copy_addr", rmtWrAddr_o, (n - 1) * CPC);
      if (n == 2) chk_eq("copy_amt5", rmtWrData_o[1], 70);
      cycle();
    end
    chk_eq("copy_done", recoverDone_o, 1);
    chk_eq("copy_done_busy", recoverBusy_o, 0);
    cycle();
    chk_eq("copy_done_pulse", recoverDone_o, 0);

    // restart at beat 9
    recoverFlag_i = 1'b1;
    cycle();
    recoverFlag_i = 1'b0;
    for (int n = 1; n <= 9; n++) begin
      if (n == 9) recoverFlag_i = 1'b1;
      cycle();
      recoverFlag_i = 1'b0;
    end
    chk_eq("restart_addr", rmtWrAddr_o, 0);
    for (int n = 1; n <= BEATS; n++) begin
      chk_eq("restart_nodone", recoverDone_o, 0);
      cycle();
    end
    chk_eq("restart_done", recoverDone_o, 1);
    cycle();

    // reset at beat 5
    recoverFlag_i = 1'b1;
    cycle();
    recoverFlag_i = 1'b0;
    for (int n = 1; n <= 4; n++) cycle();
    chk_eq("abort_pre_addr", rmtWrAddr_o, 4 * CPC);
    #2;
    reset = 1'b0;
    #1;
    chk_reset_outputs("abort");
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    for (int n = 0; n < 20; n++) begin
      chk_eq("abort_nodone", recoverDone_o, 0);
      cycle();
    end
    recoverFlag_i = 1'b1;
    cycle();
    recoverFlag_i = 1'b0;
    chk_eq("ident_a3", rmtWrData_o[3], 3);
    cycle();
    chk_eq("ident_a5", rmtWrData_o[1], 5);
    for (int n = 2; n <= BEATS; n++) cycle();
    chk_eq("ident_done", recoverDone_o, 1);
    cycle();

    // intra-group same arch
    do_reset();
    commitValid_i = 4'b1011;
    for (int i = 0; i < NCW; i++) commitArch_i[i] = 6'd7;
    commitPhy_i[0] = 7'd80; commitPhy_i[1] = 7'd81; commitPhy_i[3] = 7'd82;
    cycle();
    idle_inputs();
    chk_eq("same_f0", freedPhyReg_o[0], 8'h87);
    chk_eq("same_f1", freedPhyReg_o[1], 8'hD0);
    chk_eq("same_f2", freedPhyReg_o[2], 8'h00);
    chk_eq("same_f3", freedPhyReg_o[3], 8'hD1);

    // sparse lanes
    commitValid_i = 4'b1010;
    commitArch_i[1] = 6'd2; commitPhy_i[1] = 7'd90;
    commitArch_i[3] = 6'd9; commitPhy_i[3] = 7'd91;
    cycle();
    idle_inputs();
    chk_eq("sparse_f0", freedPhyReg_o[0], 8'h00);
    chk_eq("sparse_f1", freedPhyReg_o[1], 8'h82);
    chk_eq("sparse_f2", freedPhyReg_o[2], 8'h00);
    chk_eq("sparse_f3", freedPhyReg_o[3], 8'h89);

    recoverFlag_i = 1'b1;
    cycle();
    recoverFlag_i = 1'b0;
    chk_eq("sparse_amt2", rmtWrData_o[2], 90);
    cycle();
    chk_eq("same_amt7", rmtWrData_o[3], 82);
    cycle();
    chk_eq("sparse_amt9", rmtWrData_o[1], 91);
    for (int n = 3; n <= BEATS; n++) cycle();
    chk_eq("sparse_done", recoverDone_o, 1);
    cycle();

    // random traffic, commits overlapping copies and restarts
    for (int n = 0; n < 600; n++) begin
      bit narrow;
      narrow = ($urandom_range(0, 1) == 1);
      for (int i = 0; i < NCW; i++) begin
        commitValid_i[i] = ($urandom_range(0, 3) != 0);
        commitArch_i[i]  = narrow ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, NA - 1));
        commitPhy_i[i]   = PW'($urandom_range(0, 127));
      end
      recoverFlag_i = ($urandom_range(0, 24) == 0);
      cycle();
    end
    idle_inputs();
    for (int n = 0; n < 20; n++) cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
